// File: rtl/gbdt_argmax.sv
// Running argmax over GBDT class scores. Each round presents eight signed scores with a
// valid mask; the block snapshots them, scans one class per cycle and keeps the global
// maximum (index = round*8 + class) across rounds until clear or reset.
module gbdt_argmax #(
    parameter int SCORE_W = 16,
    parameter int CLASSES = 8
) (
    input  logic                       gbdt_clk,
    input  logic                       gbdt_rst,
    input  logic                       clear,
    input  logic                       en,
    input  logic [1:0]                 round,
    input  logic [CLASSES-1:0]         used,
    input  logic [CLASSES*SCORE_W-1:0] scores,
    output logic                       max_done,
    output logic [4:0]                 max_idx,
    output logic [SCORE_W-1:0]         max_score,
    output logic                       max_valid,
    output logic                       busy
);

    typedef enum logic [1:0] {StIdle, StScan, StDone, StWaitLow} state_t;

    state_t                       r_state;
    logic [2:0]                   r_k;
    logic [CLASSES*SCORE_W-1:0]   r_snap_scores;
    logic [CLASSES-1:0]           r_snap_used;
    logic [1:0]                   r_snap_round;
    logic                         r_max_done;
    logic [4:0]                   r_max_idx;
    logic signed [SCORE_W-1:0]    r_max_score;
    logic                         r_max_valid;
    logic                         r_busy;

    logic signed [SCORE_W-1:0]    w_cur_score;
    logic                         w_take;

    // Score under examination comes from the snapshot so input changes mid-scan are ignored.
    assign w_cur_score = $signed(r_snap_scores[r_k*SCORE_W +: SCORE_W]);
    // Strict compare keeps the earlier index on ties.
    assign w_take      = r_snap_used[r_k] && (!r_max_valid || (w_cur_score > r_max_score));

    // Control FSM with the scan datapath and registered outputs.
    always_ff @(posedge gbdt_clk or posedge gbdt_rst) begin
        if (gbdt_rst) begin
            r_state       <= StIdle;
            r_k           <= 3'd0;
            r_snap_scores <= '0;
            r_snap_used   <= '0;
            r_snap_round  <= 2'd0;
            r_max_done    <= 1'b0;
            r_max_idx     <= 5'd0;
            r_max_score   <= '0;
            r_max_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else if (clear) begin
            r_state     <= StIdle;
            r_k         <= 3'd0;
            r_max_done  <= 1'b0;
            r_max_idx   <= 5'd0;
            r_max_score <= '0;
            r_max_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_max_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (en) begin
                        r_snap_scores <= scores;
                        r_snap_used   <= used;
                        r_snap_round  <= round;
                        r_k           <= 3'd0;
                        r_busy        <= 1'b1;
                        r_state       <= StScan;
                    end
                end
                StScan: begin
                    if (w_take) begin
                        r_max_score <= w_cur_score;
                        r_max_idx   <= {r_snap_round, r_k};
                        r_max_valid <= 1'b1;
                    end
                    if (r_k == 3'd7) begin
                        r_k        <= 3'd0;
                        r_max_done <= 1'b1;
                        r_state    <= StDone;
                    end else begin
                        r_k <= r_k + 3'd1;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= en ? StWaitLow : StIdle;
                end
                StWaitLow: begin
                    // Held enable must drop before another scan can start.
                    if (!en) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign max_done  = r_max_done;
    assign max_idx   = r_max_idx;
    assign max_score = r_max_score;
    assign max_valid = r_max_valid;
    assign busy      = r_busy;

endmodule
